// File: rtl/instr_buffer_nway_pkg.sv
// Shared types and default sizing for the N-way instruction buffer.
package instr_buffer_nway_pkg;

  localparam int IB_WAYS     = 2;
  localparam int IB_DEPTH    = 16;
  localparam int IB_BS_DEPTH = 4;

  typedef logic [31:0] INSTRUCTION;
  typedef logic [31:0] PC;

  typedef struct packed {
    logic       cond_branch;
    logic       uncond_branch;
    logic [4:0] dest_reg;
  } FD_control_t;

  typedef struct packed {
    INSTRUCTION  instruction;
    FD_control_t control;
    logic        pred_taken;
    PC           pred_NPC;
    PC           not_taken_NPC;
  } IBEntry_t;

  function automatic logic is_branch(input FD_control_t c);
    return c.cond_branch | c.uncond_branch;
  endfunction

endpackage

// File: rtl/instr_buffer_nway_branch_limit.sv
// Branch-slot limiter: lane i may issue only if it and every older lane fit
// in the free branch-stack slots. The result is a thermometer mask.
module ib_branch_limit
  import instr_buffer_nway_pkg::*;
#(
  parameter int WAYS     = IB_WAYS,
  parameter int BS_DEPTH = IB_BS_DEPTH,
  localparam int BW      = $clog2(BS_DEPTH + 1)
) (
  input  logic [WAYS-1:0] lane_present,
  input  logic [WAYS-1:0] lane_is_branch,
  input  logic [BW-1:0]   bs_nEntries,
  output logic [WAYS-1:0] lane_ok
);

  always_comb begin
    int  free_slots;
    int  used;
    logic run_ok;
    free_slots = (int'(bs_nEntries) >= BS_DEPTH) ? 0 : BS_DEPTH - int'(bs_nEntries);
    used       = 0;
    run_ok     = 1'b1;
    lane_ok    = '0;
    for (int i = 0; i < WAYS; i++) begin
      used       = used + int'(lane_is_branch[i]);
      run_ok     = run_ok && lane_present[i] && (used <= free_slots);
      lane_ok[i] = run_ok;
    end
  end

endmodule

// File: rtl/instr_buffer_nway.sv
// N-way circular instruction buffer between fetch and dispatch, with
// lane compaction on enqueue and branch-stack-aware dispatch window.
module instr_buffer_nway
  import instr_buffer_nway_pkg::*;
#(
  parameter int WAYS     = IB_WAYS,
  parameter int DEPTH    = IB_DEPTH,
  parameter int BS_DEPTH = IB_BS_DEPTH,
  localparam int LW      = $clog2(WAYS + 1),
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH),
  localparam int BW      = $clog2(BS_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   br_fub_pred_wrong,
  input  logic        [WAYS-1:0] if_valid_in,
  input  INSTRUCTION  [WAYS-1:0] if_inst_in,
  input  FD_control_t [WAYS-1:0] fd_control,
  input  logic        [WAYS-1:0] bp_pred_taken,
  input  PC           [WAYS-1:0] bp_pred_NPC,
  input  PC           [WAYS-1:0] bp_not_taken_NPC,
  input  logic        [LW-1:0]   haz_nDispatched,
  input  logic        [BW-1:0]   bs_nEntries,
  output IBEntry_t    [WAYS-1:0] ib_data,
  output logic        [WAYS-1:0] ib_valid,
  output logic        [LW-1:0]   ib_nAvai,
  output logic        [CW-1:0]   ib_count,
  output logic                   ib_overflow,
  output logic        [PW-1:0]   head,
  output logic        [PW-1:0]   tail
);

  IBEntry_t buffer [DEPTH];

  logic [LW-1:0]         enq_cnt, deq_cnt, nvalid;
  logic                  overflow_now;
  logic [WAYS-1:0]       lane_present, lane_is_branch;
  logic [WAYS-1:0][PW-1:0] wr_idx;
  IBEntry_t [WAYS-1:0]   wr_entry;

  for (genvar g = 0; g < WAYS; g++) begin : g_lane
    assign ib_data[g]        = buffer[head + PW'(g)];
    assign lane_present[g]   = (CW'(g) < ib_count);
    assign lane_is_branch[g] = is_branch(ib_data[g].control);
    assign wr_entry[g]       = '{instruction:   if_inst_in[g],
                                 control:       fd_control[g],
                                 pred_taken:    bp_pred_taken[g],
                                 pred_NPC:      bp_pred_NPC[g],
                                 not_taken_NPC: bp_not_taken_NPC[g]};
  end

  ib_branch_limit #(.WAYS(WAYS), .BS_DEPTH(BS_DEPTH)) u_branch_limit (
    .lane_present  (lane_present),
    .lane_is_branch(lane_is_branch),
    .bs_nEntries   (bs_nEntries),
    .lane_ok       (ib_valid)
  );

  // Free space comes from registered occupancy only; same-cycle pops are not credited.
  always_comb begin
    if ((DEPTH - int'(ib_count)) > WAYS) ib_nAvai = LW'(WAYS);
    else                                 ib_nAvai = LW'(DEPTH - int'(ib_count));
    enq_cnt      = LW'($countones(if_valid_in));
    nvalid       = LW'($countones(ib_valid));
    deq_cnt      = (haz_nDispatched > nvalid) ? nvalid : haz_nDispatched;
    overflow_now = (enq_cnt > ib_nAvai);
  end

  // Compact valid lanes into consecutive slots starting at tail.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int i = 0; i < WAYS; i++) begin
      wr_idx[i] = tail + off;
      off       = off + PW'(if_valid_in[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !br_fub_pred_wrong && !overflow_now) begin
      for (int i = 0; i < WAYS; i++)
        if (if_valid_in[i]) buffer[wr_idx[i]] <= wr_entry[i];
    end
  end

  // An overrunning fetch group freezes the whole buffer for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      ib_count    <= '0;
      ib_overflow <= 1'b0;
    end else if (br_fub_pred_wrong) begin
      head     <= '0;
      tail     <= '0;
      ib_count <= '0;
    end else if (overflow_now) begin
      ib_overflow <= 1'b1;
    end else begin
      head     <= head + PW'(deq_cnt);
      tail     <= tail + PW'(enq_cnt);
      ib_count <= ib_count + CW'(enq_cnt) - CW'(deq_cnt);
    end
  end

endmodule

// File: tb/tb_instr_buffer_nway.sv
// Directed bench for instr_buffer_nway with a queue scoreboard of buffered entries.
module tb_instr_buffer_nway;
  import instr_buffer_nway_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset, br_fub_pred_wrong;
  logic        [1:0]    if_valid_in;
  INSTRUCTION  [1:0]    if_inst_in;
  FD_control_t [1:0]    fd_control;
  logic        [1:0]    bp_pred_taken;
  PC           [1:0]    bp_pred_NPC, bp_not_taken_NPC;
  logic        [1:0]    haz_nDispatched;
  logic        [2:0]    bs_nEntries;
  IBEntry_t    [1:0]    ib_data;
  logic        [1:0]    ib_valid, ib_nAvai;
  logic        [4:0]    ib_count;
  logic                 ib_overflow;
  logic        [3:0]    head, tail;

  instr_buffer_nway #(.WAYS(2), .DEPTH(16), .BS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .br_fub_pred_wrong(br_fub_pred_wrong),
    .if_valid_in(if_valid_in), .if_inst_in(if_inst_in), .fd_control(fd_control),
    .bp_pred_taken(bp_pred_taken), .bp_pred_NPC(bp_pred_NPC),
    .bp_not_taken_NPC(bp_not_taken_NPC), .haz_nDispatched(haz_nDispatched),
    .bs_nEntries(bs_nEntries), .ib_data(ib_data), .ib_valid(ib_valid),
    .ib_nAvai(ib_nAvai), .ib_count(ib_count), .ib_overflow(ib_overflow),
    .head(head), .tail(tail)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic br; } sb_t;
  sb_t sb[$];
  int  m_head, m_tail;
  bit  m_ovf;
  bit  ub_mode;
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] br, input logic [31:0] base,
                       input int haz, input int bs, input bit flush);
    if_valid_in = v;
    for (int i = 0; i < 2; i++) begin
      if_inst_in[i]       = base + 32'(i);
      fd_control[i]       = '{cond_branch: br[i] & ~ub_mode, uncond_branch: br[i] & ub_mode,
                              dest_reg: 5'(i + 1)};
      bp_pred_taken[i]    = br[i];
      bp_pred_NPC[i]      = base + 32'h40;
      bp_not_taken_NPC[i] = base + 32'h4;
    end
    haz_nDispatched   = 2'(haz);
    bs_nEntries       = 3'(bs);
    br_fub_pred_wrong = flush;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 32'h0, 0, 0, 1'b0);
  endtask

  // One clocked step: check DUT against the model, then advance both.
  task automatic cyc(input logic [1:0] v, input logic [1:0] br, input logic [31:0] base,
                     input int haz, input int bs, input bit flush);
    logic [1:0] mv;
    int free_s, used, nv, ndeq, navai, nenq, sz;
    drive(v, br, base, haz, bs, flush);
    sz     = sb.size();
    free_s = (bs >= 4) ? 0 : 4 - bs;
    used   = 0;
    mv     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (i >= sz) break;
      used += int'(sb[i].br);
      if (used > free_s) break;
      mv[i] = 1'b1;
    end
    nv    = $countones(mv);
    ndeq  = (haz < nv) ? haz : nv;
    navai = (16 - sz < 2) ? 16 - sz : 2;
    nenq  = $countones(v);
    chk("count", 64'(ib_count), 64'(sz));
    chk("head",  64'(head),     64'(m_head));
    chk("tail",  64'(tail),     64'(m_tail));
    chk("valid", 64'(ib_valid), 64'(mv));
    chk("navai", 64'(ib_nAvai), 64'(navai));
    chk("ovf",   64'(ib_overflow), 64'(m_ovf));
    for (int k = 0; k < nv; k++) begin
      chk("data_inst", 64'(ib_data[k].instruction), 64'(sb[k].inst));
      chk("data_br", 64'(is_branch(ib_data[k].control)), 64'(sb[k].br));
    end
    if (flush) begin
      sb.delete();
      m_head = 0;
      m_tail = 0;
    end else if (nenq > navai) begin
      m_ovf = 1'b1;
    end else begin
      for (int k = 0; k < ndeq; k++) void'(sb.pop_front());
      for (int i = 0; i < 2; i++)
        if (v[i]) sb.push_back('{inst: base + 32'(i), br: br[i]});
      m_head = (m_head + ndeq) % 16;
      m_tail = (m_tail + nenq) % 16;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(2'b11, 2'b00, 32'hBAD0, 2, 0, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_head = 0;
    m_tail = 0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    ub_mode = 1'b0;
    @(negedge clk);
    do_reset();
    idle();
    chk("rst_count", 64'(ib_count), 64'd0);
    chk("rst_head",  64'(head), 64'd0);
    chk("rst_tail",  64'(tail), 64'd0);
    chk("rst_valid", 64'(ib_valid), 64'd0);
    chk("rst_navai", 64'(ib_nAvai), 64'd2);
    chk("rst_ovf",   64'(ib_overflow), 64'd0);

    for (int k = 0; k < 3; k++) cyc(2'b11, 2'b00, 32'h100 + 32'(2 * k), 0, 0, 1'b0);
    idle();
    chk("fill3_count", 64'(ib_count), 64'd6);
    chk("fill3_tail",  64'(tail), 64'd6);
    chk("fill3_valid", 64'(ib_valid), 64'b11);
    chk("fill3_navai", 64'(ib_nAvai), 64'd2);
    for (int k = 0; k < 3; k++) cyc(2'b00, 2'b00, 32'h0, 2, 0, 1'b0);

    do_reset();
    cyc(2'b10, 2'b00, 32'hA4, 0, 0, 1'b0);
    idle();
    chk("sparse_data",  64'(ib_data[0].instruction), 64'hA5);
    chk("sparse_count", 64'(ib_count), 64'd1);
    chk("sparse_valid", 64'(ib_valid), 64'b01);
    cyc(2'b00, 2'b00, 32'h0, 1, 0, 1'b0);

    for (int k = 0; k < 8; k++) cyc(2'b11, 2'b00, 32'h200 + 32'(2 * k), 2, 0, 1'b0);
    idle();
    chk("wrap_pre_head", 64'(head), 64'd15);
    chk("wrap_pre_tail", 64'(tail), 64'd1);
    cyc(2'b11, 2'b00, 32'h300, 2, 0, 1'b0);
    idle();
    chk("wrap_head",  64'(head), 64'd1);
    chk("wrap_tail",  64'(tail), 64'd3);
    chk("wrap_count", 64'(ib_count), 64'd2);

    cyc(2'b00, 2'b00, 32'h0, 2, 0, 1'b0);
    cyc(2'b11, 2'b11, 32'h400, 0, 0, 1'b0);
    drive(2'b00, 2'b00, 32'h0, 2, 3, 1'b0);
    chk("brlim_valid", 64'(ib_valid), 64'b01);
    cyc(2'b00, 2'b00, 32'h0, 2, 3, 1'b0);
    idle();
    chk("brlim_head", 64'(head), 64'd4);
    cyc(2'b00, 2'b00, 32'h0, 2, 0, 1'b0);
    ub_mode = 1'b1;
    cyc(2'b11, 2'b11, 32'h480, 0, 0, 1'b0);
    cyc(2'b00, 2'b00, 32'h0, 2, 3, 1'b0);
    cyc(2'b00, 2'b00, 32'h0, 2, 4, 1'b0);
    cyc(2'b00, 2'b00, 32'h0, 2, 0, 1'b0);
    ub_mode = 1'b0;

    for (int k = 0; k < 7; k++) cyc(2'b11, 2'b00, 32'h500 + 32'(2 * k), 0, 0, 1'b0);
    cyc(2'b01, 2'b00, 32'h600, 0, 0, 1'b0);
    idle();
    chk("near_full_navai", 64'(ib_nAvai), 64'd1);
    cyc(2'b11, 2'b00, 32'h700, 0, 0, 1'b0);
    idle();
    chk("ovf_set",   64'(ib_overflow), 64'd1);
    chk("ovf_count", 64'(ib_count), 64'd15);
    cyc(2'b01, 2'b00, 32'h800, 0, 0, 1'b0);
    idle();
    chk("full_count", 64'(ib_count), 64'd16);
    chk("full_navai", 64'(ib_nAvai), 64'd0);

    for (int k = 0; k < 4; k++) cyc(2'b00, 2'b00, 32'h0, 2, 0, 1'b0);
    cyc(2'b00, 2'b00, 32'h0, 1, 0, 1'b0);
    idle();
    chk("pre_flush_count", 64'(ib_count), 64'd7);
    cyc(2'b11, 2'b00, 32'h900, 2, 0, 1'b1);
    idle();
    chk("flush_count", 64'(ib_count), 64'd0);
    chk("flush_head",  64'(head), 64'd0);
    chk("flush_tail",  64'(tail), 64'd0);
    chk("flush_valid", 64'(ib_valid), 64'd0);
    chk("flush_ovf",   64'(ib_overflow), 64'd1);
    cyc(2'b11, 2'b00, 32'hA00, 0, 0, 1'b0);
    cyc(2'b00, 2'b00, 32'h0, 2, 0, 1'b0);

    do_reset();
    idle();
    chk("rst2_ovf", 64'(ib_overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
